// File: rtl/hs2p_tx_link_pkg.sv
// Shared definitions for the two-phase handshake transmit link.
package hs2p_tx_link_pkg;

  typedef enum logic {IDLE_ST, WAIT_ST} hs2p_st_t;

  localparam int HS2P_DATA_W = 32;

  // Two-phase link: a transfer is outstanding while req and ack disagree.
  function automatic logic hs2p_pending(input logic req, input logic ack);
    return req != ack;
  endfunction

endpackage

// File: rtl/hs2p_tx_link_fifo.sv
// Synchronous FIFO feeding the link master. The head word is visible
// combinationally; there is no write-to-read bypass.
module hs2p_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hs2p_tx_link.sv
// Two-phase (NRZ) handshake master with an input FIFO.
// Optional ack watchdog enabled by defining HS2P_TIMEOUT_EN; without it
// err_timeout is constant 0.
module hs2p_tx_link
  import hs2p_tx_link_pkg::*;
#(
  parameter int DATA_W  = HS2P_DATA_W,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   link_req,
  output logic [DATA_W-1:0]      link_data,
  input  logic                   link_ack,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       sent_cnt,
  output logic                   err_proto,
  output logic                   err_timeout
);

  hs2p_st_t          r_state;
  logic              r_req;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_sent;
  logic              r_err_proto;

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_match;
  logic              w_launch;

  hs2p_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_launch),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // Launch whenever the link is quiet (ack matches req) and a word is queued.
  // In WAIT_ST a match is also the completion of the previous word, so the
  // next word goes out in the same cycle the previous one completes.
  always_comb begin
    w_match  = !hs2p_pending(r_req, link_ack);
    w_launch = w_match && !w_empty;
  end

  assign in_ready  = !w_full;
  assign link_req  = r_req;
  assign link_data = r_data;
  assign sent_cnt  = r_sent;
  assign err_proto = r_err_proto;

  // Link FSM: launches words, counts completions, flags stray acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE_ST;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_sent      <= '0;
      r_err_proto <= 1'b0;
    end else begin
      if (w_launch) begin
        r_data <= w_head;
        r_req  <= ~r_req;
      end
      case (r_state)
        IDLE_ST: begin
          if (!w_match)      r_err_proto <= 1'b1;
          else if (!w_empty) r_state     <= WAIT_ST;
        end
        WAIT_ST: begin
          if (w_match) begin
            r_sent <= r_sent + CNT_W'(1);
            if (w_empty) r_state <= IDLE_ST;
          end
        end
        default: r_state <= IDLE_ST;
      endcase
    end
  end

`ifdef HS2P_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] r_wdog;
  logic          r_err_to;

  assign err_timeout = r_err_to;

  // Ack watchdog: restarts on each launch, counts waiting cycles, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog   <= '0;
      r_err_to <= 1'b0;
    end else if (w_launch) begin
      r_wdog <= '0;
    end else if (r_state == WAIT_ST) begin
      if (r_wdog != WW'(TIMEOUT)) r_wdog <= r_wdog + WW'(1);
      if (r_wdog == WW'(TIMEOUT - 1)) r_err_to <= 1'b1;
    end
  end
`else
  // TIMEOUT is non-negative, so this is a constant 0; referencing it keeps
  // the parameter live in both builds.
  assign err_timeout = (TIMEOUT < 0);
`endif

endmodule
